// File: rtl/packet_assemble_buffer_pkg.sv
// Shared types for the NoC packet reassembly slice.
// Flit, packet element and slot state definitions.
package packet_assemble_buffer_pkg;

  localparam int ASSEMBLE_NUM_SLOTS_DEFAULT = 2;
  localparam int PKT_DEPTH = 4;
  localparam int TAIL_W = $clog2(PKT_DEPTH + 1);
  localparam int PID_W = 4;

  typedef enum logic [1:0] {
    HEAD = 2'd0,
    BODY = 2'd1,
    TAIL = 2'd2
  } flittype_t;

  typedef struct packed {
    logic [PID_W-1:0] packet_id;
    logic [3:0]       seq;
  } flit_id_t;

  typedef struct packed {
    flittype_t   flit_type;
    flit_id_t    flit_id;
    logic [15:0] payload;
  } flit_t;

  typedef struct packed {
    flit_t [PKT_DEPTH-1:0] buffer;
    logic [TAIL_W-1:0]     tail_index;
    logic [PID_W-1:0]      packet_id;
    logic                  is_complete;
  } packet_element_t;

  typedef enum logic [1:0] {
    FREE     = 2'd0,
    FILLING  = 2'd1,
    COMPLETE = 2'd2
  } slot_state_t;

endpackage

// File: rtl/packet_assemble_slot.sv
// One reassembly slot: state, buffer, tail index, idle timer.
// Ports: clk, rst_n, flit, load/append/free controls;
// state, pkt, evict out. Timer under PACKET_ASSEMBLE_TIMEOUT_EN.
module packet_assemble_slot
  import packet_assemble_buffer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic            clk,
  input  logic            rst_n,
  input  flit_t           flit,
  input  logic            load,
  input  logic            append,
  input  logic            free,
  output slot_state_t     state,
  output packet_element_t pkt,
  output logic            evict
);

  slot_state_t     state_q, state_d;
  packet_element_t pkt_q, pkt_d;

`ifdef PACKET_ASSEMBLE_TIMEOUT_EN
  localparam int TW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMAX =
    TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] timer_q, timer_d;

  assign evict = (state_q == FILLING) &&
                 (timer_q == TMAX);

  always_comb begin
    timer_d = timer_q;
    if (load || append) begin
      timer_d = '0;
    end else if (state_q == FILLING &&
                 timer_q != TMAX) begin
      timer_d = timer_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) timer_q <= '0;
    else        timer_q <= timer_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
  assign evict = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pkt_d   = pkt_q;
    if (free) begin
      state_d = FREE;
    end else if (load) begin
      state_d            = FILLING;
      pkt_d              = '0;
      pkt_d.buffer[0]    = flit;
      pkt_d.tail_index   = TAIL_W'(1);
      pkt_d.packet_id    = flit.flit_id.packet_id;
      pkt_d.is_complete  = 1'b0;
    end else if (append) begin
      for (int j = 0; j < PKT_DEPTH; j++) begin
        if (pkt_q.tail_index == TAIL_W'(j))
          pkt_d.buffer[j] = flit;
      end
      pkt_d.tail_index = pkt_q.tail_index + 1'b1;
      if (flit.flit_type == TAIL) begin
        pkt_d.is_complete = 1'b1;
        state_d           = COMPLETE;
      end
    end else if (evict) begin
      state_d = FREE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FREE;
      pkt_q   <= '0;
    end else begin
      state_q <= state_d;
      pkt_q   <= pkt_d;
    end
  end

  assign state = state_q;
  assign pkt   = pkt_q;

endmodule

// File: rtl/packet_assemble_buffer.sv
// Reassembles NoC flits into packets across NUM_SLOTS slots.
// Ports: nocclk, rst_n, flit in (valid/ready), packet out
// (valid/completed), busy_slots, drop pulses.
// Optional idle eviction: PACKET_ASSEMBLE_TIMEOUT_EN.
module packet_assemble_buffer
  import packet_assemble_buffer_pkg::*;
#(
  parameter int NUM_SLOTS = ASSEMBLE_NUM_SLOTS_DEFAULT,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic            nocclk,
  input  logic            rst_n,
  input  flit_t           received_flit,
  input  logic            received_flit_valid,
  output logic            received_flit_ready,
  output packet_element_t assembled_packet,
  output logic            assembled_packet_valid,
  input  logic            assembled_packet_completed,
  output logic [$clog2(NUM_SLOTS+1)-1:0] busy_slots,
  output logic            unmatched_drop,
  output logic            overflow_drop,
  output logic            timeout_drop
);

  localparam int SW =
    (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int BW = $clog2(NUM_SLOTS + 1);

  slot_state_t     st [NUM_SLOTS];
  packet_element_t pk [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] ev, ld, ap, fr;

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    packet_assemble_slot #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_slot (
      .clk   (nocclk),
      .rst_n (rst_n),
      .flit  (received_flit),
      .load  (ld[g]),
      .append(ap[g]),
      .free  (fr[g]),
      .state (st[g]),
      .pkt   (pk[g]),
      .evict (ev[g])
    );
  end

  logic          is_head;
  logic          match_any, free_any, comp_any;
  logic [SW-1:0] match_idx, free_idx, comp_idx;
  logic          over, fire, done;

  logic          valid_q, gap_q;
  logic [SW-1:0] sel_q;
  logic          unm_q, ovf_q, to_q;

  assign is_head =
    (received_flit.flit_type == HEAD);

  // Descending scan leaves the lowest hit in each index.
  // A slot being evicted this edge does not match.
  always_comb begin
    match_any = 1'b0;
    free_any  = 1'b0;
    comp_any  = 1'b0;
    match_idx = '0;
    free_idx  = '0;
    comp_idx  = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (st[i] == FILLING && !ev[i] &&
          pk[i].packet_id ==
          received_flit.flit_id.packet_id) begin
        match_any = 1'b1;
        match_idx = SW'(i);
      end
      if (st[i] == FREE) begin
        free_any = 1'b1;
        free_idx = SW'(i);
      end
      if (st[i] == COMPLETE) begin
        comp_any = 1'b1;
        comp_idx = SW'(i);
      end
    end
  end

  assign received_flit_ready =
    is_head ? (free_any || match_any) : 1'b1;
  assign fire =
    received_flit_valid && received_flit_ready;
  assign over =
    (pk[match_idx].tail_index == TAIL_W'(PKT_DEPTH));
  assign done =
    valid_q && assembled_packet_completed;

  always_comb begin
    ld = '0;
    ap = '0;
    fr = '0;
    if (fire) begin
      if (is_head) begin
        if (match_any) ld[match_idx] = 1'b1;
        else           ld[free_idx]  = 1'b1;
      end else if (match_any) begin
        if (over) fr[match_idx] = 1'b1;
        else      ap[match_idx] = 1'b1;
      end
    end
    if (done) fr[sel_q] = 1'b1;
  end

  // gap_q keeps valid low for an extra cycle after
  // each completion before the next packet is taken.
  always_ff @(posedge nocclk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      gap_q   <= 1'b0;
      sel_q   <= '0;
      unm_q   <= 1'b0;
      ovf_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      unm_q <= fire && !is_head && !match_any;
      ovf_q <= fire && !is_head && match_any && over;
      to_q  <= |ev;
      gap_q <= 1'b0;
      if (done) begin
        valid_q <= 1'b0;
        gap_q   <= 1'b1;
      end else if (!valid_q && !gap_q &&
                   comp_any) begin
        valid_q <= 1'b1;
        sel_q   <= comp_idx;
      end
    end
  end

  always_comb begin
    busy_slots = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (st[i] != FREE)
        busy_slots = busy_slots + BW'(1);
    end
  end

  assign assembled_packet =
    valid_q ? pk[sel_q] : '0;
  assign assembled_packet_valid = valid_q;
  assign unmatched_drop = unm_q;
  assign overflow_drop  = ovf_q;
  assign timeout_drop   = to_q;

endmodule

// File: tb/tb_packet_assemble_buffer.sv
// Randomized bench for packet_assemble_buffer with a
// queue-based reference model of slot reassembly.
module tb_packet_assemble_buffer;
  import packet_assemble_buffer_pkg::*;

  localparam int NS = 2;
  localparam int TO = 8;
`ifdef PACKET_ASSEMBLE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic            nocclk = 1'b0;
  logic            rst_n;
  flit_t           rx_flit;
  logic            rx_valid;
  logic            rx_ready;
  packet_element_t pkt;
  logic            pkt_valid;
  logic            pkt_done;
  logic [1:0]      busy;
  logic            unm, ovf, tod;

  always #5 nocclk = ~nocclk;

  packet_assemble_buffer #(
    .NUM_SLOTS(NS),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .nocclk                    (nocclk),
    .rst_n                     (rst_n),
    .received_flit             (rx_flit),
    .received_flit_valid       (rx_valid),
    .received_flit_ready       (rx_ready),
    .assembled_packet          (pkt),
    .assembled_packet_valid    (pkt_valid),
    .assembled_packet_completed(pkt_done),
    .busy_slots                (busy),
    .unmatched_drop            (unm),
    .overflow_drop             (ovf),
    .timeout_drop              (tod)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: 0=free 1=filling 2=complete
  int         m_state [NS];
  flit_t      m_q     [NS][$];
  logic [3:0] m_id    [NS];
  int         m_timer [NS];
  bit         m_valid, m_gap, m_unm, m_ovf, m_to;
  int         m_sel;

  task automatic m_reset();
    for (int s = 0; s < NS; s++) begin
      m_state[s] = 0;
      m_q[s].delete();
      m_id[s]    = '0;
      m_timer[s] = 0;
    end
    m_valid = 0; m_gap = 0; m_sel = 0;
    m_unm = 0; m_ovf = 0; m_to = 0;
  endtask

  function automatic bit m_evicting(int s);
    return TO_EN && m_state[s] == 1 &&
           m_timer[s] == TO - 1;
  endfunction

  function automatic int m_match(logic [3:0] id);
    for (int s = 0; s < NS; s++)
      if (m_state[s] == 1 && !m_evicting(s) &&
          m_id[s] == id) return s;
    return -1;
  endfunction

  function automatic int m_lowest(int stv);
    for (int s = 0; s < NS; s++)
      if (m_state[s] == stv) return s;
    return -1;
  endfunction

  function automatic bit m_ready(flit_t f);
    if (f.flit_type != HEAD) return 1'b1;
    return m_lowest(0) >= 0 ||
           m_match(f.flit_id.packet_id) >= 0;
  endfunction

  function automatic int m_busy();
    int n = 0;
    for (int s = 0; s < NS; s++)
      if (m_state[s] != 0) n++;
    return n;
  endfunction

  function automatic packet_element_t m_pkt(int s);
    packet_element_t p = '0;
    for (int j = 0; j < m_q[s].size(); j++)
      p.buffer[j] = m_q[s][j];
    p.tail_index  = 3'(m_q[s].size());
    p.packet_id   = m_id[s];
    p.is_complete = (m_state[s] == 2);
    return p;
  endfunction

  task automatic m_step(flit_t f, bit v, bit c);
    int  pre [NS];
    bit  evs [NS];
    int  mt, comp, fre, tgt;
    int  touched = -1;
    bit  fire, done, head;
    for (int s = 0; s < NS; s++) begin
      pre[s] = m_state[s];
      evs[s] = m_evicting(s);
    end
    head = (f.flit_type == HEAD);
    mt   = m_match(f.flit_id.packet_id);
    fire = v && m_ready(f);
    done = m_valid && c;
    comp = m_lowest(2);
    fre  = m_lowest(0);
    m_unm = 0; m_ovf = 0; m_to = 0;
    if (done) begin
      m_valid = 0;
      m_gap   = 1;
    end else begin
      if (!m_valid && !m_gap && comp >= 0) begin
        m_valid = 1;
        m_sel   = comp;
      end
      m_gap = 0;
    end
    if (fire) begin
      if (head) begin
        tgt = (mt >= 0) ? mt : fre;
        m_q[tgt].delete();
        m_q[tgt].push_back(f);
        m_id[tgt]    = f.flit_id.packet_id;
        m_state[tgt] = 1;
        m_timer[tgt] = 0;
        touched = tgt;
      end else if (mt >= 0) begin
        touched = mt;
        if (m_q[mt].size() == PKT_DEPTH) begin
          m_state[mt] = 0;
          m_q[mt].delete();
          m_ovf = 1;
        end else begin
          m_q[mt].push_back(f);
          m_timer[mt] = 0;
          if (f.flit_type == TAIL) m_state[mt] = 2;
        end
      end else begin
        m_unm = 1;
      end
    end
    if (done) begin
      m_state[m_sel] = 0;
      m_q[m_sel].delete();
    end
    for (int s = 0; s < NS; s++) begin
      if (s != touched && pre[s] == 1) begin
        if (evs[s]) begin
          m_state[s] = 0;
          m_q[s].delete();
          m_to = 1;
        end else if (TO_EN && m_timer[s] < TO - 1) begin
          m_timer[s]++;
        end
      end
    end
  endtask

  function automatic flit_t mk(int t, int id);
    flit_t f;
    f.flit_type         = flittype_t'(t);
    f.flit_id.packet_id = 4'(id);
    f.flit_id.seq       = 4'($urandom);
    f.payload           = 16'($urandom);
    return f;
  endfunction

  task automatic check_outs(string tag, flit_t f);
    packet_element_t ep;
    ep = m_valid ? m_pkt(m_sel) : '0;
    check({tag, ".rdy"}, 128'(rx_ready),
          128'(m_ready(f)));
    check({tag, ".vld"}, 128'(pkt_valid),
          128'(m_valid));
    check({tag, ".pkt"}, 128'(pkt), 128'(ep));
    check({tag, ".busy"}, 128'(busy),
          128'(m_busy()));
    check({tag, ".unm"}, 128'(unm), 128'(m_unm));
    check({tag, ".ovf"}, 128'(ovf), 128'(m_ovf));
    check({tag, ".to"}, 128'(tod), 128'(m_to));
  endtask

  task automatic cyc(string tag, flit_t f,
                     bit v, bit c);
    rx_flit  = f;
    rx_valid = v;
    pkt_done = c;
    @(negedge nocclk);
    check_outs(tag, f);
    @(posedge nocclk);
    m_step(f, v, c);
    #1;
  endtask

  task automatic fl(string tag, int t, int id);
    cyc(tag, mk(t, id), 1'b1, 1'b0);
  endtask

  task automatic idle(string tag, int n);
    for (int i = 0; i < n; i++)
      cyc(tag, mk(1, 0), 1'b0, 1'b0);
  endtask

  task automatic cmpl(string tag);
    cyc(tag, mk(1, 0), 1'b0, 1'b1);
  endtask

  task automatic check_zero(string tag);
    check({tag, ".vld"}, 128'(pkt_valid), 128'(0));
    check({tag, ".pkt"}, 128'(pkt), 128'(0));
    check({tag, ".busy"}, 128'(busy), 128'(0));
    check({tag, ".drops"}, 128'({unm, ovf, tod}),
          128'(0));
  endtask

  initial begin
    rst_n    = 1'b0;
    rx_flit  = '0;
    rx_valid = 1'b0;
    pkt_done = 1'b0;
    m_reset();
    #12;
    check_zero("rst");
    @(negedge nocclk);
    rst_n = 1'b1;
    @(posedge nocclk);
    #1;

    fl("t1", 0, 1); fl("t1", 1, 1); fl("t1", 2, 1);
    idle("t1", 3); cmpl("t1"); idle("t1", 3);

    fl("t2", 0, 1); fl("t2", 0, 2); fl("t2", 1, 2);
    fl("t2", 1, 1); fl("t2", 2, 2); fl("t2", 2, 1);
    idle("t2", 2); cmpl("t2"); idle("t2", 3);
    cmpl("t2"); idle("t2", 2);

    fl("t3", 0, 1); fl("t3", 0, 2); fl("t3", 0, 3);
    fl("t3", 0, 3); fl("t3", 0, 1); idle("t3", 1);
    fl("t3", 2, 1); fl("t3", 2, 2); idle("t3", 3);
    cmpl("t3"); idle("t3", 3); cmpl("t3");
    idle("t3", 2);

    fl("t4", 1, 7); idle("t4", 1);
    fl("t4", 0, 1); fl("t4", 1, 1); fl("t4", 1, 1);
    fl("t4", 1, 1); fl("t4", 2, 1); idle("t4", 2);

    fl("t5", 0, 4); idle("t5", 15);
    fl("t5", 2, 4); idle("t5", 3); cmpl("t5");
    idle("t5", 2);

    fl("t6", 0, 1); fl("t6", 1, 1); fl("t6", 2, 1);
    fl("t6", 0, 2); idle("t6", 2);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("t6.arst");
    m_reset();
    @(negedge nocclk);
    rst_n = 1'b1;
    @(posedge nocclk);
    #1;
    fl("t6", 0, 5); fl("t6", 1, 5); fl("t6", 2, 5);
    idle("t6", 3); cmpl("t6"); idle("t6", 2);

    for (int i = 0; i < 3000; i++) begin
      int r;
      int t;
      r = $urandom_range(0, 9);
      t = (r < 3) ? 0 : (r < 7) ? 1 : 2;
      cyc("rnd", mk(t, $urandom_range(1, 3)),
          ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 2) == 0));
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
